// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the per-button input conditioner.
//   state_t                : FSM state encoding (3 bits; codes 5..7 unused)
//   DEF_DEBOUNCE_CYCLES    : default debounce window (10 ms at 50 MHz)
//   DEF_REPEAT_DELAY       : default press-to-first-repeat delay (300 ms)
//   DEF_REPEAT_PERIOD      : default repeat interval (100 ms)
//   DEF_CNT_W              : default interval counter width
package button_conditioner_pkg;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      DEB_PRESS   = 3'd1,
      HELD_DELAY  = 3'd2,
      HELD_REPEAT = 3'd3,
      DEB_RELEASE = 3'd4
   } state_t;

   localparam int DEF_DEBOUNCE_CYCLES = 500000;
   localparam int DEF_REPEAT_DELAY    = 15000000;
   localparam int DEF_REPEAT_PERIOD   = 5000000;
   localparam int DEF_CNT_W           = 24;

endpackage

// File: rtl/button_conditioner_counter.sv
// interval_counter: up-counter that stops at a programmable terminal value.
//   clk      : clock
//   rst      : synchronous active-high reset, count -> 0
//   clear    : synchronous clear, count -> 0 (wins over enable)
//   enable   : advance the count by one
//   terminal : value at which done asserts
//   done     : count == terminal (combinational from the count register)
module interval_counter #(
   parameter int W = 24
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         enable,
   input  logic [W-1:0] terminal,
   output logic         done
);

   logic [W-1:0] count;

   assign done = (count == terminal);

   // Holding at the terminal value means the count can never wrap, even if
   // the owner keeps enable high for a cycle too long.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable && !done) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: debounces one synchronized button level and produces
// registered single-cycle press / auto-repeat / release pulses.
//   clk           : clock, all logic on posedge
//   rst           : synchronous active-high reset
//   btn_sync      : synchronized button level, 1 = pressed
//   rep_en        : auto-repeat enable for this button
//   pressed       : debounced button level
//   press_pulse   : one cycle on an accepted press
//   repeat_pulse  : one cycle per auto-repeat event
//   release_pulse : one cycle on an accepted release
module button_conditioner
   import button_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
   parameter int CNT_W           = DEF_CNT_W
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_sync,
   input  logic rep_en,
   output logic pressed,
   output logic press_pulse,
   output logic repeat_pulse,
   output logic release_pulse
);

   localparam logic [CNT_W-1:0] DEB_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DLY_TERM = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PER_TERM = CNT_W'(REPEAT_PERIOD - 1);

   state_t           state_q, state_d;
   logic             cnt_clear, cnt_en, cnt_done;
   logic [CNT_W-1:0] cnt_term;
   logic             pressed_d, press_d, repeat_d, release_d;

   interval_counter #(.W(CNT_W)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .clear    (cnt_clear),
      .enable   (cnt_en),
      .terminal (cnt_term),
      .done     (cnt_done)
   );

   // The terminal value depends only on which interval is being timed.
   always_comb begin
      cnt_term = DEB_TERM;
      case (state_q)
         HELD_DELAY:  cnt_term = DLY_TERM;
         HELD_REPEAT: cnt_term = PER_TERM;
         default:     cnt_term = DEB_TERM;
      endcase
   end

   // Within every state the button level is checked first, then rep_en,
   // then the counter terminal. Every state change also clears the counter.
   always_comb begin
      state_d   = state_q;
      cnt_clear = 1'b0;
      cnt_en    = 1'b0;
      press_d   = 1'b0;
      repeat_d  = 1'b0;
      release_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (btn_sync) begin
               state_d   = DEB_PRESS;
               cnt_clear = 1'b1;
            end
         end
         DEB_PRESS: begin
            if (!btn_sync) begin
               state_d   = IDLE;
               cnt_clear = 1'b1;
            end else if (cnt_done) begin
               state_d   = HELD_DELAY;
               cnt_clear = 1'b1;
               press_d   = 1'b1;
            end else begin
               cnt_en = 1'b1;
            end
         end
         HELD_DELAY: begin
            if (!btn_sync) begin
               state_d   = DEB_RELEASE;
               cnt_clear = 1'b1;
            end else if (!rep_en) begin
               // Repeat disabled: park the delay timer at zero.
               cnt_clear = 1'b1;
            end else if (cnt_done) begin
               state_d   = HELD_REPEAT;
               cnt_clear = 1'b1;
               repeat_d  = 1'b1;
            end else begin
               cnt_en = 1'b1;
            end
         end
         HELD_REPEAT: begin
            if (!btn_sync) begin
               state_d   = DEB_RELEASE;
               cnt_clear = 1'b1;
            end else if (!rep_en) begin
               state_d   = HELD_DELAY;
               cnt_clear = 1'b1;
            end else if (cnt_done) begin
               cnt_clear = 1'b1;
               repeat_d  = 1'b1;
            end else begin
               cnt_en = 1'b1;
            end
         end
         DEB_RELEASE: begin
            if (btn_sync) begin
               // Release glitch: still held, restart the repeat delay.
               state_d   = HELD_DELAY;
               cnt_clear = 1'b1;
            end else if (cnt_done) begin
               state_d   = IDLE;
               cnt_clear = 1'b1;
               release_d = 1'b1;
            end else begin
               cnt_en = 1'b1;
            end
         end
         default: begin
            state_d   = IDLE;
            cnt_clear = 1'b1;
         end
      endcase
   end

   // The debounced level is high in every state that follows an accepted
   // press and precedes an accepted release.
   assign pressed_d = (state_d == HELD_DELAY) || (state_d == HELD_REPEAT) ||
                      (state_d == DEB_RELEASE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         pressed       <= 1'b0;
         press_pulse   <= 1'b0;
         repeat_pulse  <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         state_q       <= state_d;
         pressed       <= pressed_d;
         press_pulse   <= press_d;
         repeat_pulse  <= repeat_d;
         release_pulse <= release_d;
      end
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner with short timing parameters.
// The reference model tracks runs of raw samples and an edge-time anchor for
// the repeat schedule; expected outputs go through exp_q.
module tb_button_conditioner;
   import button_conditioner_pkg::*;

   localparam int DEB = 4;
   localparam int RD  = 10;
   localparam int RP  = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_sync = 1'b0;
   logic rep_en = 1'b0;
   logic pressed, press_pulse, repeat_pulse, release_pulse;

   int n_checks = 0;
   int n_errors = 0;

   // Scoreboard: {pressed, press, repeat, release} expected after each edge.
   logic [3:0] exp_q[$];

   // Reference model state.
   bit m_pressed   = 1'b0;
   int m_run       = 0;   // consecutive raw samples opposing the debounced level
   int m_anchor    = 0;   // edge from which the current repeat interval is timed
   bit m_repeating = 1'b0;
   int now         = 0;   // global edge index

   // Per-scenario edge index and pulse logs.
   int cur_edge = 0;
   int press_log[$];
   int repeat_log[$];
   int release_log[$];

   button_conditioner #(
      .DEBOUNCE_CYCLES (DEB),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP),
      .CNT_W           (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .btn_sync      (btn_sync),
      .rep_en        (rep_en),
      .pressed       (pressed),
      .press_pulse   (press_pulse),
      .repeat_pulse  (repeat_pulse),
      .release_pulse (release_pulse)
   );

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Model: apply one sampled edge and push the expected outputs.
   task automatic model_edge(input logic b, input logic r, input logic rs);
      bit p = 0, rp = 0, rl = 0;
      if (rs) begin
         m_pressed = 0;
         m_run = 0;
         m_repeating = 0;
      end else if (!m_pressed) begin
         if (b) begin
            m_run++;
            if (m_run == DEB + 1) begin
               m_pressed = 1; p = 1; m_run = 0;
               m_anchor = now; m_repeating = 0;
            end
         end else begin
            m_run = 0;
         end
      end else begin
         if (!b) begin
            m_run++;
            if (m_run == DEB + 1) begin
               m_pressed = 0; rl = 1; m_run = 0;
            end
         end else if (m_run > 0) begin
            m_run = 0; m_anchor = now; m_repeating = 0;
         end else if (!r) begin
            m_anchor = now; m_repeating = 0;
         end else if ((!m_repeating && (now - m_anchor) == RD) ||
                      (m_repeating && (now - m_anchor) == RP)) begin
            rp = 1; m_repeating = 1; m_anchor = now;
         end
      end
      exp_q.push_back({m_pressed, p, rp, rl});
      now++;
   endtask

   // Driver: set inputs, take one edge, check outputs #1 later.
   task automatic step(input logic b, input logic r, input logic rs);
      logic [3:0] e;
      int idx;
      btn_sync = b;
      rep_en   = r;
      rst      = rs;
      @(posedge clk);
      model_edge(b, r, rs);
      idx = cur_edge;
      cur_edge++;
      #1;
      e = exp_q.pop_front();
      check("pressed", 32'(pressed), 32'(e[3]));
      check("press_pulse", 32'(press_pulse), 32'(e[2]));
      check("repeat_pulse", 32'(repeat_pulse), 32'(e[1]));
      check("release_pulse", 32'(release_pulse), 32'(e[0]));
      if (press_pulse)   press_log.push_back(idx);
      if (repeat_pulse)  repeat_log.push_back(idx);
      if (release_pulse) release_log.push_back(idx);
   endtask

   task automatic start_scenario();
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      press_log.delete();
      repeat_log.delete();
      release_log.delete();
      cur_edge = 0;
   endtask

   initial begin
      logic [0:8] bounce;
      bit rb, rr;
      int run_left;

      #1;
      // Reset state.
      start_scenario();
      check("rst_pressed", 32'(pressed), 32'd0);
      check("rst_state", 32'(dut.state_q), 32'(IDLE));

      // 1: clean press, repeat disabled.
      start_scenario();
      for (int i = 0; i < 55; i++) step(1'b1, 1'b0, 1'b0);
      check("t1_press_n", press_log.size(), 1);
      check("t1_press_at", press_log[0], 4);
      check("t1_repeat_n", repeat_log.size(), 0);
      check("t1_pressed", 32'(pressed), 32'd1);

      // 2: bounce rejection.
      start_scenario();
      bounce = 9'b111011111;
      for (int i = 0; i < 9; i++) step(bounce[i], 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
      check("t2_press_n", press_log.size(), 1);
      check("t2_press_at", press_log[0], 8);

      // 3a: sustained auto-repeat.
      start_scenario();
      for (int i = 0; i < 25; i++) step(1'b1, 1'b1, 1'b0);
      check("t3a_repeat_n", repeat_log.size(), 4);
      check("t3a_rep0", repeat_log[0], 14);
      check("t3a_rep1", repeat_log[1], 17);
      check("t3a_rep2", repeat_log[2], 20);
      check("t3a_rep3", repeat_log[3], 23);

      // 3b: rep_en dropped at edge 18.
      start_scenario();
      for (int i = 0; i < 26; i++) step(1'b1, (i < 18), 1'b0);
      check("t3b_repeat_n", repeat_log.size(), 2);
      check("t3b_rep1", repeat_log[1], 17);

      // 4: release after 5 low samples.
      start_scenario();
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
      check("t4_release_n", release_log.size(), 1);
      check("t4_release_at", release_log[0], 14);
      check("t4_pressed", 32'(pressed), 32'd0);
      check("t4_state", 32'(dut.state_q), 32'(IDLE));
      step(1'b0, 1'b0, 1'b0);
      check("t4_release_once", release_log.size(), 1);

      // 5: release glitch of 2 low samples.
      start_scenario();
      for (int i = 0; i < 21; i++) step((i != 6 && i != 7), 1'b1, 1'b0);
      check("t5_release_n", release_log.size(), 0);
      check("t5_rep0", repeat_log[0], 18);
      check("t5_pressed", 32'(pressed), 32'd1);

      // 6: reset mid-hold in the repeat phase.
      start_scenario();
      for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      check("t6_rst_out", 32'({pressed, press_pulse, repeat_pulse, release_pulse}), 32'd0);
      for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 1'b0);
      check("t6_press_n", press_log.size(), 2);
      check("t6_press_at", press_log[1], 20);
      check("t6_repeat_n", repeat_log.size(), 1);

      // 7: randomized runs of button levels, rep_en toggles, rare resets.
      start_scenario();
      rb = 0; rr = 1; run_left = 0;
      for (int i = 0; i < 3000; i++) begin
         if (run_left == 0) begin
            rb = ~rb;
            run_left = $urandom_range(1, 20);
         end
         run_left--;
         if ($urandom_range(0, 39) == 0) rr = ~rr;
         step(rb, rr, ($urandom_range(0, 499) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
